hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers of the MIPS core. It sits directly downstream of the instruction decoder in the execute stage: it consumes the decoded HI/LO write strobes, the R-type funct field and the two register-file operands, and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It drives HI/LO to the MFHI/MFLO datapath and raises a stall while a multi-cycle operation is in flight.

## Interface

No parameters; all widths are fixed at 32 bits.

- clk  input  1  core clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- start  input  1  decoder HI or LO write strobe for the current instruction
- funct  input  6  R-type funct field
- op_a  input  32  rs value: multiplicand, dividend or MTHI/MTLO source
- op_b  input  32  rt value: multiplier or divisor
- hilo_read  input  1  current instruction is MFHI or MFLO
- hi  output  32  HI register
- lo  output  32  LO register
- busy  output  1  multi-cycle operation in flight
- done  output  1  one-cycle pulse after HI/LO are written by MULT/MULTU/DIV/DIVU
- stall  output  1  busy && (start || hilo_read); holds the pipeline

## Operation

- Recognised funct codes:
  - 011000 MULT
  - 011001 MULTU
  - 011010 DIV
  - 011011 DIVU
  - 010001 MTHI
  - 010011 MTLO
- start with any other funct is ignored.
- State machine has four states: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with MTHI: hi <= op_a. start with MTLO: lo <= op_a. One cycle, no busy.
  - start with MULT/MULTU: latch |op_a| and |op_b| (raw values for unsigned), record the result sign, go to MUL.
  - start with DIV/DIVU: latch the operands the same way, go to DIV.
- MUL: radix-2 shift-add, 64-bit accumulator, 32 iterations, then FIX.
- DIV: restoring shift-subtract, 32 iterations, then FIX.
- FIX: apply sign correction, write hi/lo, pulse done, return to IDLE.
- Signed multiply: {hi,lo} is the full 64-bit two's-complement product.
- Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
- Results: lo = quotient, hi = remainder.
- Divide by zero (signed or unsigned): lo = 32'hFFFFFFFF, hi = op_a. No exception is raised.
- Signed 32'h80000000 / 32'hFFFFFFFF: lo = 32'h80000000, hi = 0.
- start while busy is not accepted; the decoder re-presents it because stall is high.
- Reset mid-operation aborts the operation; hi, lo and the accumulators clear.

## Timing

- Reset values: hi = 0, lo = 0, busy = 0, done = 0, stall = 0, state IDLE.
- Edge E0: a MULT/MULTU/DIV/DIVU request is accepted.
- busy is high for the 33 cycles after E0: 32 iteration cycles plus FIX.
- Edge E33: hi and lo are updated and busy falls on this same edge. done is high for the cycle after E33.
- MTHI/MTLO: the register updates at E0 and the new value is visible the next cycle. There is no done pulse.
- stall is combinational from busy, start and hilo_read, with no added latency.
- MFHI/MFLO issued in the cycle after E33 reads the new values without stalling.

## Configuration

- HILO_FAST_MULT_EN
  - Defined: MULT/MULTU use a single-cycle combinational 32x32 multiplier. hi/lo are written at E0, done pulses the next cycle, and busy never asserts for multiplies. The MUL state is unused.
  - Undefined: the 33-cycle iterative multiply described above.
  - Division is iterative in both builds.

## Test plan

- Reset, then MTHI 32'hDEADBEEF and MTLO 32'h12345678 -> hi = DEADBEEF and lo = 12345678 one cycle later; busy stays 0.
- MULT op_a = 32'hFFFFFFFE (-2), op_b = 3 -> after 33 busy cycles hi = FFFFFFFF, lo = FFFFFFFA, one-cycle done pulse. Fast build: same result one cycle after E0.
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi = FFFFFFFE, lo = 00000001.
- DIV -7 / 2 -> lo = FFFFFFFD, hi = FFFFFFFF. DIVU 7 / 0 -> lo = FFFFFFFF, hi = 7. DIV 80000000 / FFFFFFFF -> lo = 80000000, hi = 0.
- DIVU started, then hilo_read held high -> stall = 1 for all 33 busy cycles and 0 in the cycle after E33. A second start during busy is ignored; hi/lo reflect only the first operation.
- Reset asserted at cycle 10 of a DIV -> next cycle hi = lo = 0, busy = 0, done never pulses; a new MULTU 5 x 6 then yields lo = 30, hi = 0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Multi-cycle multiply/divide unit that owns the architectural HI/LO
//   registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//   Multiply uses radix-2 shift-add over 32 iterations. Divide uses
//   restoring shift-subtract over 32 iterations. Both are followed by a
//   FIX cycle that applies sign correction and writes HI/LO.
//
// Build option (macro): HILO_FAST_MULT_EN
//   Defined   : MULT/MULTU complete in one cycle on a combinational
//               32x32 multiplier. HI/LO are written at acceptance, done
//               pulses the next cycle and busy never asserts.
//   Undefined : iterative multiply (33 busy cycles).
//   Divide is iterative in both builds.
//
// Ports
//   clk, reset       : clock, synchronous active-high reset
//   start            : HI/LO write strobe from the decoder
//   funct            : R-type funct field
//   op_a, op_b       : rs / rt operands
//   hilo_read        : current instruction is MFHI/MFLO
//   hi, lo           : architectural HI/LO
//   busy             : multi-cycle operation in flight
//   done             : one-cycle pulse after HI/LO are written by mul/div
//   stall            : busy && (start || hilo_read)
//   state_dbg        : FSM state (0 IDLE, 1 MUL, 2 DIV, 3 FIX)
//
// Handshake: a request is accepted on a rising edge where start is high
// and the unit is idle. While busy, start is not accepted; stall stays
// high so the decoder holds and re-presents the instruction.
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        hilo_read,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall,
  output logic [1:0]  state_dbg
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] op_x;    // mul: shifting multiplicand; div: divisor in [31:0]
  logic [31:0] op_y;    // mul: shifting multiplier; div: dividend -> quotient
  logic [63:0] acc;     // mul: product; div: partial remainder in [31:0]
  logic        q_neg;   // negate product / quotient in FIX
  logic        r_neg;   // negate remainder in FIX
  logic        div_zero;
  logic        op_is_div;

  // Request decode
  logic        accept, is_mult, is_div, is_signed;
  logic [31:0] abs_a, abs_b;

  assign accept    = start && (state == S_IDLE);
  assign is_mult   = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign abs_a     = (is_signed && op_a[31]) ? -op_a : op_a;
  assign abs_b     = (is_signed && op_b[31]) ? -op_b : op_b;

  // Restoring divide step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits. 33 bits because the
  // shifted remainder can exceed 32 bits when the divisor is large.
  logic [32:0] div_trial, div_diff;
  logic        div_ge;
  assign div_trial = {acc[31:0], op_y[31]};
  assign div_diff  = div_trial - {1'b0, op_x[31:0]};
  assign div_ge    = div_trial >= {1'b0, op_x[31:0]};

`ifdef HILO_FAST_MULT_EN
  logic [63:0] ext_a, ext_b, fast_prod;
  assign ext_a     = {{32{is_signed & op_a[31]}}, op_a};
  assign ext_b     = {{32{is_signed & op_b[31]}}, op_b};
  assign fast_prod = ext_a * ext_b;
`endif

  assign busy      = (state != S_IDLE);
  assign stall     = busy && (start || hilo_read);
  assign state_dbg = state;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_div) begin
          state_next = S_DIV;
        end
`ifndef HILO_FAST_MULT_EN
        else if (accept && is_mult) begin
          state_next = S_MUL;
        end
`endif
      end
      S_MUL, S_DIV: begin
        if (cnt == 5'd31) state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      cnt       <= '0;
      op_x      <= '0;
      op_y      <= '0;
      acc       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      div_zero  <= 1'b0;
      op_is_div <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (funct == F_MTHI) hi <= op_a;
            if (funct == F_MTLO) lo <= op_a;
`ifdef HILO_FAST_MULT_EN
            if (is_mult) begin
              hi   <= fast_prod[63:32];
              lo   <= fast_prod[31:0];
              done <= 1'b1;
            end
`else
            if (is_mult) begin
              op_x      <= {32'd0, abs_a};
              op_y      <= abs_b;
              acc       <= '0;
              cnt       <= '0;
              q_neg     <= is_signed & (op_a[31] ^ op_b[31]);
              op_is_div <= 1'b0;
            end
`endif
            if (is_div) begin
              op_x      <= {32'd0, abs_b};
              op_y      <= abs_a;
              acc       <= '0;
              cnt       <= '0;
              q_neg     <= is_signed & (op_a[31] ^ op_b[31]);
              r_neg     <= is_signed & op_a[31];
              div_zero  <= (op_b == 32'd0);
              op_is_div <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (op_y[0]) acc <= acc + op_x;
          op_x <= {op_x[62:0], 1'b0};
          op_y <= {1'b0, op_y[31:1]};
          cnt  <= cnt + 5'd1;
        end
        S_DIV: begin
          acc[31:0] <= div_ge ? div_diff[31:0] : div_trial[31:0];
          op_y      <= {op_y[30:0], div_ge};
          cnt       <= cnt + 5'd1;
        end
        S_FIX: begin
          done <= 1'b1;
          if (op_is_div) begin
            // Remainder follows the dividend's sign, which also makes a
            // divide by zero return the original op_a in HI.
            hi <= r_neg ? -acc[31:0] : acc[31:0];
            if (div_zero) lo <= 32'hFFFF_FFFF;
            else          lo <= q_neg ? -op_y : op_y;
          end else begin
            {hi, lo} <= q_neg ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hilo_read = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  hilo_muldiv_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .hilo_read (hilo_read),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .stall     (stall),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    hilo_read = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Checker
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: present a request for one edge (E0), return at the negedge after E0
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    funct = f;
    op_a  = a;
    op_b  = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles (bounded) and return at the negedge after busy falls
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(f, a, b);
    wait_idle(n);
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_busy));
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, " done_clear"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int stall_bad;
    int done_seen;

    do_reset();
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst stall", 64'(stall), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);

    // MTHI / MTLO: visible the cycle after E0, no busy, no done
    issue(F_MTHI, 32'hDEADBEEF, 32'h0);
    check("mthi hi", 64'(hi), 64'hDEADBEEF);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    issue(F_MTLO, 32'h12345678, 32'h0);
    check("mtlo lo", 64'(lo), 64'h12345678);
    check("mtlo hi_kept", 64'(hi), 64'hDEADBEEF);
    check("mtlo busy", 64'(busy), 64'd0);

    // Unrecognised funct is ignored
    issue(F_ADD, 32'h1111_1111, 32'h2222_2222);
    check("add hi", 64'(hi), 64'hDEADBEEF);
    check("add lo", 64'(lo), 64'h12345678);
    check("add busy", 64'(busy), 64'd0);

    run_op("mult_neg2x3",   F_MULT,  32'hFFFFFFFE, 32'd3,        MUL_BUSY, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max",     F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_BUSY, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_minxmin",  F_MULT,  32'h80000000, 32'h80000000, MUL_BUSY, 32'h40000000, 32'h00000000);
    run_op("mult_3xneg5",   F_MULT,  32'd3,        32'hFFFFFFFB, MUL_BUSY, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("div_neg7_2",    F_DIV,   32'hFFFFFFF9, 32'd2,        DIV_BUSY, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_neg2",    F_DIV,   32'd7,        32'hFFFFFFFE, DIV_BUSY, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_7_0",      F_DIVU,  32'd7,        32'd0,        DIV_BUSY, 32'h00000007, 32'hFFFFFFFF);
    run_op("div_neg7_0",    F_DIV,   32'hFFFFFFF9, 32'd0,        DIV_BUSY, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("div_min_neg1",  F_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_BUSY, 32'h00000000, 32'h80000000);
    run_op("divu_big",      F_DIVU,  32'hFFFFFFFF, 32'h80000000, DIV_BUSY, 32'h7FFFFFFF, 32'h00000001);

    // Stall while busy with hilo_read held; a second start during busy is ignored
    issue(F_DIVU, 32'd100, 32'd7);
    hilo_read = 1'b1;
    start = 1'b1;
    funct = F_MTHI;
    op_a  = 32'hAAAA_AAAA;
    n = 0;
    stall_bad = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) stall_bad++;
      n++;
      if (n == 4) start = 1'b0;
      @(negedge clk);
    end
    check("stall busy_cycles", 64'(n), 64'd33);
    check("stall held", 64'(stall_bad), 64'd0);
    check("stall after", 64'(stall), 64'd0);
    check("stall done", 64'(done), 64'd1);
    check("stall hi", 64'(hi), 64'd2);
    check("stall lo", 64'(lo), 64'd14);
    hilo_read = 1'b0;
    @(negedge clk);

    // Reset during a divide aborts it
    issue(F_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort state", 64'(state_dbg), 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("abort no_done", 64'(done_seen), 64'd0);
    run_op("multu_5x6", F_MULTU, 32'd5, 32'd6, MUL_BUSY, 32'd0, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
